// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; the line format (divisor, parity, stop bits)
// is sampled from the cfg_* inputs at every frame start.
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [PAYLOAD_BITS-1:0]       s_data,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(PAYLOAD_BITS);
  localparam logic [BW-1:0] LAST = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [FIFO_DEPTH-1:0][PAYLOAD_BITS-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           level;
  logic                    push, pop, empty, full;

  state_t                  state, state_n;
  logic [DIV_WIDTH-1:0]    cnt, div_q;
  logic [BW-1:0]           bit_idx;
  logic                    stop_idx;
  logic [PAYLOAD_BITS-1:0] shreg, data_q;
  logic [1:0]              par_q;
  logic                    stop2_q, txd, bit_end, par_en, par_bit;

  assign empty      = (level == '0);
  assign full       = (level == LW'(FIFO_DEPTH));
  assign s_ready    = !full;
  assign push       = s_valid && s_ready;
  assign fifo_level = level;
  assign uart_txd   = txd;
  assign tx_busy    = (state != IDLE);
  assign bit_end    = (cnt == div_q);
  // 01 even, 10 odd; 00/11 disable parity
  assign par_en     = par_q[0] ^ par_q[1];
  assign par_bit    = (^data_q) ^ par_q[1];

  // Storage has no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE:   if (!empty) begin state_n = START; pop = 1'b1; end
      START:  if (bit_end) state_n = DATA;
      DATA:   if (bit_end && bit_idx == LAST) state_n = par_en ? PARITY : STOP;
      PARITY: if (bit_end) state_n = STOP;
      STOP:   if (bit_end && (!stop2_q || stop_idx)) begin
                // Back-to-back frames: next start bit follows the last stop bit directly.
                if (!empty) begin state_n = START; pop = 1'b1; end
                else        state_n = IDLE;
              end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      txd      <= 1'b1;
      cnt      <= '0;
      div_q    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      data_q   <= '0;
      par_q    <= '0;
      stop2_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state == IDLE || bit_end) ? '0 : cnt + DIV_WIDTH'(1);
      if (pop) begin
        shreg   <= mem[rd_ptr];
        data_q  <= mem[rd_ptr];
        div_q   <= cfg_div;
        par_q   <= cfg_parity;
        stop2_q <= cfg_stop2;
        txd     <= 1'b0;
      end else if (bit_end) begin
        case (state)
          START: begin
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
          DATA: begin
            if (bit_idx == LAST) begin
              txd      <= par_en ? par_bit : 1'b1;
              stop_idx <= 1'b0;
            end else begin
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + BW'(1);
            end
          end
          PARITY: begin
            txd      <= 1'b1;
            stop_idx <= 1'b0;
          end
          STOP:    stop_idx <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shape, parity, FIFO full/refill, stop2,
// mid-frame config change and mid-frame reset.
module tb_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        uart_txd;
  logic        tx_busy;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.PAYLOAD_BITS(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .uart_txd(uart_txd), .tx_busy(tx_busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 200) begin n++; @(negedge clk); end
    chk("push_ready", (n < 200), 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Samples every cycle of a frame; gap = cycles of idle seen before the start bit.
  task automatic check_frame(input string tag, input int d, input int nb,
                             input logic [11:0] exp, input int exp_gap);
    logic [11:0] bits = '0;
    int gap = 0, bad = 0;
    logic v;
    @(negedge clk);
    while (uart_txd !== 1'b0 && gap < 500) begin gap++; @(negedge clk); end
    chk({tag, "_start"}, (gap < 500), 1);
    for (int c = 0; c < nb * (d + 1); c++) begin
      if (c > 0) @(negedge clk);
      v = uart_txd;
      if (c % (d + 1) == 0) bits[c / (d + 1)] = v;
      else if (v !== bits[c / (d + 1)]) bad++;
    end
    chk({tag, "_bits"}, bits, exp);
    chk({tag, "_steady"}, bad, 0);
    if (exp_gap >= 0) chk({tag, "_gap"}, gap, exp_gap);
  endtask

  task automatic count_busy(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b1) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w[6] = '{8'h11, 8'h22, 8'h3C, 8'h81, 8'hFF, 8'h00};
    int exp_lvl[13] = '{0, 1, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 3};
    int busy_n, sent, zeros;

    resetn = 1'b0; cfg_div = 16'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_ready", s_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_level", fifo_level, 0);
    resetn = 1'b1;
    @(negedge clk);

    // 8N1, 4 cycles per bit, 0xA5 -> start, 1010_0101 LSB first, stop
    push(8'hA5);
    fork
      check_frame("t1", 3, 10, 12'h34A, 0);
      count_busy(60, busy_n);
    join
    chk("t1_busy", busy_n, 40);
    chk("t1_idle", uart_txd, 1);

    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    cfg_div = 16'd1; cfg_parity = 2'b01;
    push(8'h07);
    fork
      check_frame("t2e", 1, 11, 12'h60E, 0);
      count_busy(40, busy_n);
    join
    chk("t2e_busy", busy_n, 22);
    cfg_parity = 2'b10;
    push(8'h07);
    check_frame("t2o", 1, 11, 12'h40E, 0);
    cfg_parity = 2'b00;

    // Fill past full with 1-cycle bits; FIFO refills while frames run
    cfg_div = 16'd0;
    sent = 0;
    fork
      begin
        for (int c = 0; c < 13; c++) begin
          chk($sformatf("t3_lvl%0d", c), fifo_level, exp_lvl[c]);
          chk($sformatf("t3_rdy%0d", c), s_ready, (exp_lvl[c] != 4));
          if (sent < 6) begin s_valid = 1'b1; s_data = w[sent]; end
          else s_valid = 1'b0;
          if (s_valid && s_ready) sent++;
          @(posedge clk);
          @(negedge clk);
        end
        s_valid = 1'b0;
        chk("t3_sent", sent, 6);
      end
      begin
        for (int k = 0; k < 6; k++)
          check_frame($sformatf("t3_f%0d", k), 0, 10, {3'b0, 1'b1, w[k], 1'b0}, (k == 0) ? -1 : 0);
      end
    join
    repeat (3) @(negedge clk);
    chk("t3_empty", fifo_level, 0);
    chk("t3_busy", tx_busy, 0);

    // Two stop bits; divisor changes while the first frame is on the line
    cfg_div = 16'd1; cfg_stop2 = 1'b1;
    fork
      begin
        push(8'h5A);
        push(8'hC3);
        repeat (3) @(negedge clk);
        cfg_div = 16'd2;
      end
      begin
        check_frame("t4a", 1, 11, 12'h6B4, -1);
        check_frame("t4b", 2, 11, 12'h786, 0);
      end
    join
    cfg_stop2 = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of DATA with three words still queued
    cfg_div = 16'd3;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("t5_level_pre", fifo_level, 3);
    repeat (8) @(negedge clk);
    chk("t5_busy_pre", tx_busy, 1);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_txd", uart_txd, 1);
    chk("t5_level", fifo_level, 0);
    chk("t5_busy", tx_busy, 0);
    chk("t5_ready", s_ready, 1);
    resetn = 1'b1;
    zeros = 0;
    busy_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) zeros++;
      if (tx_busy !== 1'b0) busy_n++;
    end
    chk("t5_no_frame", zeros, 0);
    chk("t5_no_busy", busy_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
